// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: multi-cycle timing/control unit for the model computer.
// Sequences each instruction through FETCH, DECODE and EXEC beats, plus
// IMM / EXEC2 for instructions carrying an immediate word and WAIT_IO for
// the port handshakes. Control strobes come from the current state and the
// opcode latched at the end of DECODE. The exceptions are the WAIT_IO
// handshake strobes and the jg choice in IMM, which also depend on the
// inputs sampled in that same cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   run                 leave IDLE when high
//   mova..halt          one-hot instruction lines from the decoder
//   gt_flag             ALU greater-than flag (used by jg in IMM)
//   in_valid, out_ready I/O device handshakes
//   dec_en, ir_ld, pc_inc, pc_ld, mem_rd, mem_wr, addr_sel, addr_ld,
//   reg_we, reg_src, alu_sub, flag_ld, in_ack, out_ld
//                       datapath control strobes
//   halted              level, high in HALT
//   state               current state, for debug
module ctrl_sequencer #(
    parameter int IO_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       mova,
    input  logic       movb,
    input  logic       movc,
    input  logic       movd,
    input  logic       movi,
    input  logic       add,
    input  logic       sub,
    input  logic       jmp,
    input  logic       jg,
    input  logic       in1,
    input  logic       out1,
    input  logic       halt,
    input  logic       gt_flag,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       dec_en,
    output logic       ir_ld,
    output logic       pc_inc,
    output logic       pc_ld,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic [1:0] addr_sel,
    output logic       addr_ld,
    output logic       reg_we,
    output logic [1:0] reg_src,
    output logic       alu_sub,
    output logic       flag_ld,
    output logic       in_ack,
    output logic       out_ld,
    output logic       halted,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_EXEC    = 3'd3,
        S_IMM     = 3'd4,
        S_EXEC2   = 3'd5,
        S_WAIT_IO = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    // Bit positions of each instruction inside the latched opcode vector.
    localparam int OP_MOVA = 11;
    localparam int OP_MOVB = 10;
    localparam int OP_MOVC = 9;
    localparam int OP_MOVD = 8;
    localparam int OP_MOVI = 7;
    localparam int OP_ADD  = 6;
    localparam int OP_SUB  = 5;
    localparam int OP_JMP  = 4;
    localparam int OP_JG   = 3;
    localparam int OP_IN1  = 2;
    localparam int OP_OUT1 = 1;
    localparam int OP_HALT = 0;

    // The counter only has to reach IO_TIMEOUT-1.
    localparam int CW = (IO_TIMEOUT > 1) ? $clog2(IO_TIMEOUT) : 1;

    state_t          r_state;
    state_t          w_state_next;
    logic [11:0]     r_op;
    logic [11:0]     w_lines;
    logic            w_onehot;
    logic [CW-1:0]   r_io_cnt;
    logic [CW-1:0]   w_io_cnt_next;
    logic            w_timeout;

    assign w_lines = {mova, movb, movc, movd, movi, add, sub,
                      jmp, jg, in1, out1, halt};

    // Exactly one line set; zero or several lines decode as a NOP.
    assign w_onehot = (w_lines != 12'd0) &&
                      ((w_lines & (w_lines - 12'd1)) == 12'd0);

    // A timeout of 0 disables the limit, so WAIT_IO can last forever.
    assign w_timeout = (IO_TIMEOUT > 0) && (r_io_cnt == CW'(IO_TIMEOUT - 1));

    assign state = r_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_op     <= 12'd0;
            r_io_cnt <= '0;
        end else begin
            r_state  <= w_state_next;
            r_io_cnt <= w_io_cnt_next;
            if (r_state == S_DECODE) begin
                r_op <= w_lines;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_io_cnt_next = '0;
        dec_en        = 1'b0;
        ir_ld         = 1'b0;
        pc_inc        = 1'b0;
        pc_ld         = 1'b0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        addr_sel      = 2'd0;
        addr_ld       = 1'b0;
        reg_we        = 1'b0;
        reg_src       = 2'd0;
        alu_sub       = 1'b0;
        flag_ld       = 1'b0;
        in_ack        = 1'b0;
        out_ld        = 1'b0;
        halted        = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (run) begin
                    w_state_next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_rd       = 1'b1;
                ir_ld        = 1'b1;
                pc_inc       = 1'b1;
                w_state_next = S_DECODE;
            end

            S_DECODE: begin
                dec_en       = 1'b1;
                w_state_next = w_onehot ? S_EXEC : S_FETCH;
            end

            S_EXEC: begin
                // r_op is guaranteed one-hot here, so the priority order
                // below never has to resolve a conflict.
                dec_en       = 1'b1;
                w_state_next = S_FETCH;
                if (r_op[OP_MOVA]) begin
                    reg_we = 1'b1;
                end else if (r_op[OP_MOVB]) begin
                    mem_wr   = 1'b1;
                    addr_sel = 2'd1;
                end else if (r_op[OP_MOVC]) begin
                    mem_rd   = 1'b1;
                    addr_sel = 2'd1;
                    reg_we   = 1'b1;
                    reg_src  = 2'd2;
                end else if (r_op[OP_ADD] || r_op[OP_SUB]) begin
                    reg_we  = 1'b1;
                    reg_src = 2'd1;
                    flag_ld = 1'b1;
                    alu_sub = r_op[OP_SUB];
                end else if (r_op[OP_MOVI] || r_op[OP_MOVD] ||
                             r_op[OP_JMP]  || r_op[OP_JG]) begin
                    w_state_next = S_IMM;
                end else if (r_op[OP_IN1] || r_op[OP_OUT1]) begin
                    w_state_next = S_WAIT_IO;
                end else if (r_op[OP_HALT]) begin
                    w_state_next = S_HALT;
                end
            end

            S_IMM: begin
                // The immediate word sits at the current PC.
                mem_rd       = 1'b1;
                w_state_next = S_FETCH;
                if (r_op[OP_MOVI]) begin
                    reg_we  = 1'b1;
                    reg_src = 2'd2;
                    pc_inc  = 1'b1;
                end else if (r_op[OP_MOVD]) begin
                    addr_ld      = 1'b1;
                    pc_inc       = 1'b1;
                    w_state_next = S_EXEC2;
                end else if (r_op[OP_JMP]) begin
                    pc_ld = 1'b1;
                end else if (r_op[OP_JG]) begin
                    // Not taken still has to step over the immediate word.
                    pc_ld  = gt_flag;
                    pc_inc = !gt_flag;
                end
            end

            S_EXEC2: begin
                mem_rd       = 1'b1;
                addr_sel     = 2'd2;
                reg_we       = 1'b1;
                reg_src      = 2'd2;
                w_state_next = S_FETCH;
            end

            S_WAIT_IO: begin
                if (r_op[OP_IN1] && in_valid) begin
                    reg_we       = 1'b1;
                    reg_src      = 2'd3;
                    in_ack       = 1'b1;
                    w_state_next = S_FETCH;
                end else if (r_op[OP_OUT1] && out_ready) begin
                    out_ld       = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_timeout) begin
                    w_state_next = S_FETCH;
                end else if (IO_TIMEOUT > 0) begin
                    w_io_cnt_next = r_io_cnt + CW'(1);
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Testbench for ctrl_sequencer. Two instances share all inputs: dut0 waits
// forever for I/O, and dut4 gives up after 4 WAIT_IO cycles. Each test
// pushes the expected per-cycle output word onto a scoreboard queue as it
// drives stimulus, and the observed word is captured on the falling edge.
// At the end of each test the task drains both queues and compares them.
// Output word layout:
//   [19:17] state, [16] halted, [15] dec_en, [14] ir_ld, [13] pc_inc,
//   [12] pc_ld, [11] mem_rd, [10] mem_wr, [9:8] addr_sel, [7] addr_ld,
//   [6] reg_we, [5:4] reg_src, [3] alu_sub, [2] flag_ld, [1] in_ack, [0] out_ld
module tb_ctrl_sequencer;

    localparam logic [16:0] NONE = 17'h0;
    localparam logic [16:0] HLT  = 17'h1 << 16;
    localparam logic [16:0] DEC  = 17'h1 << 15;
    localparam logic [16:0] IRL  = 17'h1 << 14;
    localparam logic [16:0] PCI  = 17'h1 << 13;
    localparam logic [16:0] PCL  = 17'h1 << 12;
    localparam logic [16:0] MRD  = 17'h1 << 11;
    localparam logic [16:0] MWR  = 17'h1 << 10;
    localparam logic [16:0] AS1  = 17'h1 << 8;
    localparam logic [16:0] AS2  = 17'h2 << 8;
    localparam logic [16:0] ADL  = 17'h1 << 7;
    localparam logic [16:0] RWE  = 17'h1 << 6;
    localparam logic [16:0] RS1  = 17'h1 << 4;
    localparam logic [16:0] RS2  = 17'h2 << 4;
    localparam logic [16:0] RS3  = 17'h3 << 4;
    localparam logic [16:0] SUB  = 17'h1 << 3;
    localparam logic [16:0] FLG  = 17'h1 << 2;
    localparam logic [16:0] ACK  = 17'h1 << 1;
    localparam logic [16:0] OLD  = 17'h1;
    localparam logic [16:0] FET  = MRD | IRL | PCI;

    // Decoder line order: {mova,movb,movc,movd,movi,add,sub,jmp,jg,in1,out1,halt}
    localparam logic [11:0] L_MOVA = 12'h800;
    localparam logic [11:0] L_MOVB = 12'h400;
    localparam logic [11:0] L_MOVC = 12'h200;
    localparam logic [11:0] L_MOVD = 12'h100;
    localparam logic [11:0] L_MOVI = 12'h080;
    localparam logic [11:0] L_ADD  = 12'h040;
    localparam logic [11:0] L_SUB  = 12'h020;
    localparam logic [11:0] L_JMP  = 12'h010;
    localparam logic [11:0] L_JG   = 12'h008;
    localparam logic [11:0] L_IN1  = 12'h004;
    localparam logic [11:0] L_OUT1 = 12'h002;
    localparam logic [11:0] L_HALT = 12'h001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [11:0] lines = 12'h0;
    logic        gt_flag = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        sel4 = 1'b0;

    logic       dec_en0, ir_ld0, pc_inc0, pc_ld0, mem_rd0, mem_wr0, addr_ld0;
    logic       reg_we0, alu_sub0, flag_ld0, in_ack0, out_ld0, halted0;
    logic [1:0] addr_sel0, reg_src0;
    logic [2:0] state0;
    logic       dec_en4, ir_ld4, pc_inc4, pc_ld4, mem_rd4, mem_wr4, addr_ld4;
    logic       reg_we4, alu_sub4, flag_ld4, in_ack4, out_ld4, halted4;
    logic [1:0] addr_sel4, reg_src4;
    logic [2:0] state4;

    logic [19:0] obs0, obs4;
    logic [19:0] exp_q[$];
    logic [19:0] obs_q[$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    ctrl_sequencer #(.IO_TIMEOUT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mova(lines[11]), .movb(lines[10]), .movc(lines[9]), .movd(lines[8]),
        .movi(lines[7]), .add(lines[6]), .sub(lines[5]), .jmp(lines[4]),
        .jg(lines[3]), .in1(lines[2]), .out1(lines[1]), .halt(lines[0]),
        .gt_flag(gt_flag), .in_valid(in_valid), .out_ready(out_ready),
        .dec_en(dec_en0), .ir_ld(ir_ld0), .pc_inc(pc_inc0), .pc_ld(pc_ld0),
        .mem_rd(mem_rd0), .mem_wr(mem_wr0), .addr_sel(addr_sel0),
        .addr_ld(addr_ld0), .reg_we(reg_we0), .reg_src(reg_src0),
        .alu_sub(alu_sub0), .flag_ld(flag_ld0), .in_ack(in_ack0),
        .out_ld(out_ld0), .halted(halted0), .state(state0)
    );

    ctrl_sequencer #(.IO_TIMEOUT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .run(run),
        .mova(lines[11]), .movb(lines[10]), .movc(lines[9]), .movd(lines[8]),
        .movi(lines[7]), .add(lines[6]), .sub(lines[5]), .jmp(lines[4]),
        .jg(lines[3]), .in1(lines[2]), .out1(lines[1]), .halt(lines[0]),
        .gt_flag(gt_flag), .in_valid(in_valid), .out_ready(out_ready),
        .dec_en(dec_en4), .ir_ld(ir_ld4), .pc_inc(pc_inc4), .pc_ld(pc_ld4),
        .mem_rd(mem_rd4), .mem_wr(mem_wr4), .addr_sel(addr_sel4),
        .addr_ld(addr_ld4), .reg_we(reg_we4), .reg_src(reg_src4),
        .alu_sub(alu_sub4), .flag_ld(flag_ld4), .in_ack(in_ack4),
        .out_ld(out_ld4), .halted(halted4), .state(state4)
    );

    assign obs0 = {state0, halted0, dec_en0, ir_ld0, pc_inc0, pc_ld0, mem_rd0,
                   mem_wr0, addr_sel0, addr_ld0, reg_we0, reg_src0, alu_sub0,
                   flag_ld0, in_ack0, out_ld0};
    assign obs4 = {state4, halted4, dec_en4, ir_ld4, pc_inc4, pc_ld4, mem_rd4,
                   mem_wr4, addr_sel4, addr_ld4, reg_we4, reg_src4, alu_sub4,
                   flag_ld4, in_ack4, out_ld4};

    task automatic push(input logic [2:0] st, input logic [16:0] m);
        exp_q.push_back({st, m});
    endtask

    // Inputs are set #1 after a rising edge; outputs are sampled on the
    // falling edge, half a cycle away from the active edge.
    task automatic tick();
        @(negedge clk);
        obs_q.push_back(sel4 ? obs4 : obs0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic start_run();
        run = 1'b1;
        push(3'd0, NONE);
        tick();
        run = 1'b0;
    endtask

    // FETCH beat followed by DECODE with the given lines asserted.
    task automatic fetch_decode(input logic [11:0] l);
        push(3'd1, FET);
        tick();
        lines = l;
        push(3'd2, DEC);
        tick();
        lines = 12'h0;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            push(3'd0, NONE);
            tick();
        end
        start_run();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL reset: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("reset: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_alu();
        apply_reset();
        start_run();
        fetch_decode(L_ADD);
        push(3'd3, DEC | RWE | RS1 | FLG);
        tick();
        fetch_decode(L_SUB);
        push(3'd3, DEC | RWE | RS1 | FLG | SUB);
        tick();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alu: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("alu: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_moves();
        apply_reset();
        start_run();
        fetch_decode(L_MOVA);
        push(3'd3, DEC | RWE);
        tick();
        fetch_decode(L_MOVB);
        push(3'd3, DEC | MWR | AS1);
        tick();
        fetch_decode(L_MOVC);
        push(3'd3, DEC | MRD | AS1 | RWE | RS2);
        tick();
        fetch_decode(L_MOVI);
        push(3'd3, DEC);
        tick();
        push(3'd4, MRD | RWE | RS2 | PCI);
        tick();
        fetch_decode(L_JMP);
        push(3'd3, DEC);
        tick();
        push(3'd4, MRD | PCL);
        tick();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL moves: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("moves: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_jg();
        apply_reset();
        start_run();
        // Taken: gt_flag only matters in the IMM cycle.
        fetch_decode(L_JG);
        push(3'd3, DEC);
        tick();
        gt_flag = 1'b1;
        push(3'd4, MRD | PCL);
        tick();
        gt_flag = 1'b0;
        // Not taken, with gt_flag high in EXEC to show it is ignored there.
        fetch_decode(L_JG);
        gt_flag = 1'b1;
        push(3'd3, DEC);
        tick();
        gt_flag = 1'b0;
        push(3'd4, MRD | PCI);
        tick();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL jg: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("jg: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_movd();
        apply_reset();
        start_run();
        fetch_decode(L_MOVD);
        push(3'd3, DEC);
        tick();
        push(3'd4, MRD | ADL | PCI);
        tick();
        push(3'd5, MRD | AS2 | RWE | RS2);
        tick();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL movd: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("movd: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_io_wait();
        apply_reset();
        start_run();
        fetch_decode(L_IN1);
        push(3'd3, DEC);
        tick();
        // out_ready is high throughout but must not satisfy an in1 wait.
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(3'd6, NONE);
            tick();
        end
        out_ready = 1'b0;
        in_valid = 1'b1;
        push(3'd6, RWE | RS3 | ACK);
        tick();
        in_valid = 1'b0;
        // out1 with the device already ready: one WAIT_IO cycle.
        fetch_decode(L_OUT1);
        push(3'd3, DEC);
        tick();
        out_ready = 1'b1;
        push(3'd6, OLD);
        tick();
        out_ready = 1'b0;
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL io_wait: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("io_wait: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_io_timeout();
        sel4 = 1'b1;
        apply_reset();
        start_run();
        fetch_decode(L_OUT1);
        push(3'd3, DEC);
        tick();
        for (int i = 0; i < 4; i++) begin
            push(3'd6, NONE);
            tick();
        end
        push(3'd1, FET);
        tick();
        // A second stall must count from zero again.
        push(3'd2, DEC);
        lines = L_OUT1;
        tick();
        lines = 12'h0;
        push(3'd3, DEC);
        tick();
        for (int i = 0; i < 4; i++) begin
            push(3'd6, NONE);
            tick();
        end
        push(3'd1, FET);
        tick();
        sel4 = 1'b0;
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL io_timeout: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("io_timeout: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        start_run();
        fetch_decode(L_HALT);
        push(3'd3, DEC);
        tick();
        for (int i = 0; i < 20; i++) begin
            run = (i % 2) == 0;
            push(3'd7, HLT);
            tick();
        end
        run = 1'b0;
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL halt: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("halt: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_illegal();
        apply_reset();
        start_run();
        fetch_decode(12'h000);
        fetch_decode(L_ADD | L_SUB);
        fetch_decode(L_MOVA | L_HALT);
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL illegal: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("illegal: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        start_run();
        fetch_decode(L_IN1);
        push(3'd3, DEC);
        tick();
        push(3'd6, NONE);
        tick();
        rst_n = 1'b0;
        push(3'd6, NONE);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(3'd0, NONE);
            tick();
        end
        start_run();
        push(3'd1, FET);
        tick();
        while (exp_q.size() > 0) begin
            logic [19:0] e, o;
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 20'hxxxxx;
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL mid_reset: got st=%0d str=%05h exp st=%0d str=%05h", o[19:17], o[16:0], e[19:17], e[16:0]);
            end else $display("mid_reset: st=%0d str=%05h ok", o[19:17], o[16:0]);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_moves();
        test_jg();
        test_movd();
        test_io_wait();
        test_io_timeout();
        test_halt();
        test_illegal();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
